// File: rtl/msk_sbox_scheduler.sv
// Round-robin scheduler sharing one fixed-latency masked S-box pipeline
// between NREQ requesters. Issues only when fresh randomness is offered and
// tags every returning result with the index of the requester that issued it.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           synchronous flush of all in-flight tokens
//   req             per-requester level request, held until granted
//   in_data         masked bytes, requester i at [i*8*D +: 8*D]
//   gnt             one-hot grant (combinational, same cycle as issue)
//   rnd_valid       fresh randomness word available
//   rnd_take        randomness consumed (equals issue)
//   sbox_in         shares of the granted requester, zero when idle
//   sbox_in_valid   issue strobe into the S-box pipeline
//   out_valid       S-box result for out_id is valid this cycle
//   out_id          requester index of the returning result
//   pend            per-requester outstanding-token flag
//   busy            any token in flight
module msk_sbox_scheduler #(
  parameter int unsigned D    = 2,
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*8*D-1:0]   in_data,
  output logic [NREQ-1:0]       gnt,
  input  logic                  rnd_valid,
  output logic                  rnd_take,
  output logic [8*D-1:0]        sbox_in,
  output logic                  sbox_in_valid,
  output logic                  out_valid,
  output logic [IDW-1:0]        out_id,
  output logic [NREQ-1:0]       pend,
  output logic                  busy
);

  localparam int unsigned SW = 8 * D;

  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [LAT-1:0]  tok_vld_q, tok_vld_d;
  logic [IDW-1:0]  tok_id_q [LAT];
  logic [IDW-1:0]  tok_id_d [LAT];
  logic [NREQ-1:0] pend_q, pend_d;

  logic [NREQ-1:0] eligible;
  logic [IDW-1:0]  winner;
  logic            found;
  logic            issue;
  int unsigned     idx;

  // Round-robin search starting one past the last granted index.
  // Issue is also held off while reset is asserted so gnt reads zero.
  always_comb begin
    eligible = req & ~pend_q;
    winner   = '0;
    found    = 1'b0;
    idx      = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && eligible[IDW'(idx)]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
    issue = found & rnd_valid & ~clear & rst_n;
  end

  // Issue-side outputs: share-wise select, never combined across shares.
  always_comb begin
    gnt     = '0;
    sbox_in = '0;
    if (issue) begin
      gnt[winner] = 1'b1;
      sbox_in     = in_data[32'(winner)*SW +: SW];
    end
  end

  assign sbox_in_valid = issue;
  assign rnd_take      = issue;

  // Next state: pointer, token shift register, pending flags.
  always_comb begin
    ptr_d = issue ? winner : ptr_q;

    tok_vld_d[0] = issue;
    tok_id_d[0]  = issue ? winner : '0;
    for (int unsigned i = 1; i < LAT; i++) begin
      tok_vld_d[i] = tok_vld_q[i-1];
      tok_id_d[i]  = tok_id_q[i-1];
    end

    // A returning token frees its requester from the next cycle on; the
    // returning requester cannot be the winner since it is still pending.
    pend_d = pend_q;
    if (tok_vld_q[LAT-1]) pend_d[tok_id_q[LAT-1]] = 1'b0;
    if (issue)            pend_d[winner]          = 1'b1;

    if (clear) begin
      tok_vld_d = '0;
      pend_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= IDW'(NREQ - 1);
      tok_vld_q <= '0;
      pend_q    <= '0;
      for (int unsigned i = 0; i < LAT; i++) tok_id_q[i] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      tok_vld_q <= tok_vld_d;
      pend_q    <= pend_d;
      for (int unsigned i = 0; i < LAT; i++) tok_id_q[i] <= tok_id_d[i];
    end
  end

  assign out_valid = tok_vld_q[LAT-1];
  assign out_id    = tok_id_q[LAT-1];
  assign pend      = pend_q;
  assign busy      = |pend_q;

endmodule

// File: tb/tb_msk_sbox_scheduler.sv
// Scoreboard bench: stimulus pushes expected {id, due cycle} per issue,
// monitors pop and compare whenever a DUT shows out_valid.
// DUT a: D=2, NREQ=4, LAT=4.  DUT b: D=2, NREQ=3, LAT=1.
module tb_msk_sbox_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_tot  = 0;

  logic [15:0] lane [4] = '{16'hA55A, 16'h1234, 16'hBEEF, 16'hC0DE};

  // DUT a
  logic        clear_a = 1'b0, rnd_valid_a = 1'b0;
  logic [3:0]  req_a = '0, gnt_a, pend_a;
  logic [63:0] in_data_a;
  logic        rnd_take_a, sbox_in_valid_a, out_valid_a, busy_a;
  logic [15:0] sbox_in_a;
  logic [1:0]  out_id_a;

  // DUT b
  logic        clear_b = 1'b0, rnd_valid_b = 1'b0;
  logic [2:0]  req_b = '0, gnt_b, pend_b;
  logic [47:0] in_data_b;
  logic        rnd_take_b, sbox_in_valid_b, out_valid_b, busy_b;
  logic [15:0] sbox_in_b;
  logic [1:0]  out_id_b;

  assign in_data_a = {lane[3], lane[2], lane[1], lane[0]};
  assign in_data_b = {lane[2], lane[1], lane[0]};

  msk_sbox_scheduler #(.D(2), .NREQ(4), .LAT(4), .IDW(2)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(clear_a), .req(req_a), .in_data(in_data_a),
    .gnt(gnt_a), .rnd_valid(rnd_valid_a), .rnd_take(rnd_take_a), .sbox_in(sbox_in_a),
    .sbox_in_valid(sbox_in_valid_a), .out_valid(out_valid_a), .out_id(out_id_a),
    .pend(pend_a), .busy(busy_a));

  msk_sbox_scheduler #(.D(2), .NREQ(3), .LAT(1), .IDW(2)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(clear_b), .req(req_b), .in_data(in_data_b),
    .gnt(gnt_b), .rnd_valid(rnd_valid_b), .rnd_take(rnd_take_b), .sbox_in(sbox_in_b),
    .sbox_in_valid(sbox_in_valid_b), .out_valid(out_valid_b), .out_id(out_id_b),
    .pend(pend_b), .busy(busy_b));

  int qa_id[$], qa_due[$], qb_id[$], qb_due[$];
  int ea_id, ea_due, eb_id, eb_due;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h, want %0h", name, act, exp);
    else n_pass++;
  endtask

  function automatic int oh_idx(input logic [3:0] oh);
    int r = 0;
    for (int i = 0; i < 4; i++) if (oh[i]) r = i;
    return r;
  endfunction

  function automatic logic [15:0] exp_sbox(input logic [3:0] oh);
    if (oh == 4'b0) return 16'h0;
    return lane[oh_idx(oh)];
  endfunction

  // Monitors: every shown result must match the head of the scoreboard,
  // and a due result must not be missing.
  always @(negedge clk) begin
    if (rst_n && out_valid_a) begin
      if (qa_id.size() == 0) begin
        n_tot++;
        $display("FAIL a_unexpected_out: got out_id %0d at cycle %0d, want no result", out_id_a, cyc);
      end else begin
        ea_id  = qa_id.pop_front();
        ea_due = qa_due.pop_front();
        chk("a_out_id", 32'(out_id_a), 32'(ea_id));
        chk("a_out_cycle", 32'(cyc), 32'(ea_due));
      end
    end else if (rst_n && qa_due.size() != 0 && qa_due[0] == cyc) begin
      n_tot++;
      $display("FAIL a_missing_out: got none at cycle %0d, want out_id %0d", cyc, qa_id[0]);
      void'(qa_id.pop_front());
      void'(qa_due.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid_b) begin
      if (qb_id.size() == 0) begin
        n_tot++;
        $display("FAIL b_unexpected_out: got out_id %0d at cycle %0d, want no result", out_id_b, cyc);
      end else begin
        eb_id  = qb_id.pop_front();
        eb_due = qb_due.pop_front();
        chk("b_out_id", 32'(out_id_b), 32'(eb_id));
        chk("b_out_cycle", 32'(cyc), 32'(eb_due));
      end
    end else if (rst_n && qb_due.size() != 0 && qb_due[0] == cyc) begin
      n_tot++;
      $display("FAIL b_missing_out: got none at cycle %0d, want out_id %0d", cyc, qb_id[0]);
      void'(qb_id.pop_front());
      void'(qb_due.pop_front());
    end
  end

  // One cycle on DUT a: drive, check combinational/issue outputs and pend.
  task automatic cyc_a(input string t, input int c, input logic [3:0] r, input logic rv,
                       input logic clr, input logic [3:0] eg, input logic [3:0] ep);
    req_a = r; rnd_valid_a = rv; clear_a = clr;
    @(negedge clk);
    chk($sformatf("%s_c%0d_gnt", t, c), 32'(gnt_a), 32'(eg));
    chk($sformatf("%s_c%0d_take", t, c), 32'(rnd_take_a), 32'(|eg));
    chk($sformatf("%s_c%0d_sbox", t, c), 32'(sbox_in_a), 32'(exp_sbox(eg)));
    chk($sformatf("%s_c%0d_pend", t, c), 32'(pend_a), 32'(ep));
    chk($sformatf("%s_c%0d_busy", t, c), 32'(busy_a), 32'(|ep));
    if (eg != 4'b0) begin
      qa_id.push_back(oh_idx(eg));
      qa_due.push_back(cyc + 4);
    end
    @(posedge clk); #1;
  endtask

  task automatic cyc_b(input int c, input logic [2:0] r, input logic [2:0] eg, input logic [2:0] ep);
    req_b = r; rnd_valid_b = 1'b1; clear_b = 1'b0;
    @(negedge clk);
    chk($sformatf("b_c%0d_gnt", c), 32'(gnt_b), 32'(eg));
    chk($sformatf("b_c%0d_sbox", c), 32'(sbox_in_b), 32'(exp_sbox({1'b0, eg})));
    chk($sformatf("b_c%0d_pend", c), 32'(pend_b), 32'(ep));
    if (eg != 3'b0) begin
      qb_id.push_back(oh_idx({1'b0, eg}));
      qb_due.push_back(cyc + 1);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req_a = '0; rnd_valid_a = 1'b0; clear_a = 1'b0; req_b = '0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_gnt", 32'(gnt_a), 32'h0);
    chk("rst_out_valid", 32'(out_valid_a), 32'h0);
    chk("rst_out_id", 32'(out_id_a), 32'h0);
    chk("rst_pend", 32'(pend_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_sbox", 32'(sbox_in_a), 32'h0);
    qa_id.delete(); qa_due.delete();
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1;
    do_reset();

    // Single request, result after LAT cycles.
    cyc_a("single", 0, 4'b0001, 1'b1, 1'b0, 4'b0001, 4'b0000);
    for (int c = 1; c <= 4; c++) cyc_a("single", c, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0001);
    cyc_a("single", 5, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000);

    // Round-robin fairness from reset, all requesting.
    do_reset();
    cyc_a("rr", 0, 4'b1111, 1'b1, 1'b0, 4'b0001, 4'b0000);
    cyc_a("rr", 1, 4'b1111, 1'b1, 1'b0, 4'b0010, 4'b0001);
    cyc_a("rr", 2, 4'b1111, 1'b1, 1'b0, 4'b0100, 4'b0011);
    cyc_a("rr", 3, 4'b1111, 1'b1, 1'b0, 4'b1000, 4'b0111);
    cyc_a("rr", 4, 4'b1111, 1'b1, 1'b0, 4'b0000, 4'b1111);
    cyc_a("rr", 5, 4'b1111, 1'b1, 1'b0, 4'b0001, 4'b1110);
    cyc_a("rr", 6, 4'b1111, 1'b1, 1'b0, 4'b0010, 4'b1101);
    cyc_a("rr", 7, 4'b1111, 1'b1, 1'b0, 4'b0100, 4'b1011);
    cyc_a("rr", 8, 4'b1111, 1'b1, 1'b0, 4'b1000, 4'b0111);
    cyc_a("rr", 9, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b1111);
    cyc_a("rr", 10, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b1110);
    cyc_a("rr", 11, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b1100);
    cyc_a("rr", 12, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b1000);
    cyc_a("rr", 13, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000);

    // Randomness starvation.
    for (int c = 0; c <= 2; c++) cyc_a("starve", c, 4'b0100, 1'b0, 1'b0, 4'b0000, 4'b0000);
    cyc_a("starve", 3, 4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0000);
    for (int c = 4; c <= 7; c++) cyc_a("starve", c, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0100);
    cyc_a("starve", 8, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000);

    // Clear mid-flight: index 2 would win at cycle 2 without the clear.
    do_reset();
    cyc_a("clear", 0, 4'b0011, 1'b1, 1'b0, 4'b0001, 4'b0000);
    cyc_a("clear", 1, 4'b0011, 1'b1, 1'b0, 4'b0010, 4'b0001);
    cyc_a("clear", 2, 4'b0111, 1'b1, 1'b1, 4'b0000, 4'b0011);
    qa_id.delete(); qa_due.delete();
    cyc_a("clear", 3, 4'b0100, 1'b1, 1'b0, 4'b0100, 4'b0000);
    for (int c = 4; c <= 7; c++) cyc_a("clear", c, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0100);
    cyc_a("clear", 8, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000);

    // Async reset mid-flight after two issues (pointer last at 2 -> 0, 1).
    cyc_a("arst", 0, 4'b0011, 1'b1, 1'b0, 4'b0001, 4'b0000);
    cyc_a("arst", 1, 4'b0011, 1'b1, 1'b0, 4'b0010, 4'b0001);
    req_a = 4'b1111;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid_a), 32'h0);
    chk("arst_pend", 32'(pend_a), 32'h0);
    chk("arst_gnt", 32'(gnt_a), 32'h0);
    chk("arst_busy", 32'(busy_a), 32'h0);
    qa_id.delete(); qa_due.delete();
    req_a = 4'b0000;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc_a("arst", 2, 4'b1111, 1'b1, 1'b0, 4'b0001, 4'b0000);
    for (int c = 3; c <= 6; c++) cyc_a("arst", c, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0001);
    cyc_a("arst", 7, 4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000);

    // NREQ=3, LAT=1: pointer wraps 2 -> 0.
    cyc_b(0, 3'b111, 3'b001, 3'b000);
    cyc_b(1, 3'b111, 3'b010, 3'b001);
    cyc_b(2, 3'b111, 3'b100, 3'b010);
    cyc_b(3, 3'b111, 3'b001, 3'b100);
    cyc_b(4, 3'b111, 3'b010, 3'b001);
    cyc_b(5, 3'b000, 3'b000, 3'b010);
    cyc_b(6, 3'b000, 3'b000, 3'b000);

    repeat (2) @(posedge clk);
    #1;
    chk("a_drained", 32'(qa_id.size()), 32'h0);
    chk("b_drained", 32'(qb_id.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
